i2c_cmd_master: RTL and testbench
=================================

# i2c_cmd_master

Byte-level I2C controller (initiator) driving the same open-drain SCL/SDA pair our I2C slave memory responds on. Accepts a stream of START/STOP/SEND/RECV commands, generates the bus waveforms, and returns slave ACK bits and received bytes on a response stream. Sits between a CPU- or sequencer-driven command FIFO and the board I2C pads (tri-state buffers outside this block).

## Interface
- CLKS_PER_QTR, default 250: i_clk cycles per quarter SCL bit period (100 kHz at 100 MHz); legal range 2..4095.
- i_clk  in  1  system clock, all logic rising-edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- s_cmd_valid  in  1  command valid.
- s_cmd_ready  out  1  command accepted when valid&&ready.
- s_cmd_data  in  11  [10:8] opcode, [7:0] byte for SEND.
- m_rsp_valid  out  1  response valid.
- m_rsp_ready  in  1  response accepted when valid&&ready.
- m_rsp_data  out  9  [8] ACK bit as seen on bus (0 = ACK), [7:0] received byte (0 for SEND).
- i_i2c_scl, i_i2c_sda  in  1 each  raw pad inputs (2FF synchronised internally).
- o_i2c_scl, o_i2c_sda  out  1 each  1 = release (high-Z), 0 = drive low.
- o_busy  out  1  bus owned: set by completed START, cleared by completed STOP.
- o_err  out  1  one-cycle pulse on a rejected command.

## Operation
- Opcodes: 1 START, 2 STOP, 3 SEND, 4 RECV_ACK (controller ACKs), 5 RECV_NACK (controller NACKs). 0,6,7 illegal.
- s_cmd_ready = (state==IDLE) && !m_rsp_valid.
- Rejected (accepted, consumed, o_err pulse, no bus activity, no response): illegal opcode; SEND/RECV/STOP with o_busy=0.
- START with o_busy=1 is a repeated start.
- States: IDLE, START, STOP, BIT. Accept moves to START/STOP/BIT, quarter index q=0; completion returns to IDLE.
- Each phase is 4 quarters q0..q3, CLKS_PER_QTR cycles each.
- START: q0 SCL=(o_busy?0:1),SDA=1; q1 SCL=1,SDA=1; q2 SCL=1,SDA=0; q3 SCL=0,SDA=0. Then o_busy<=1.
- STOP: q0 SCL=0,SDA=0; q1 SCL=1,SDA=0; q2,q3 SCL=1,SDA=1. Then o_busy<=0.
- BIT: 9 bits, index 0..8, MSB first. Per bit: q0 SCL=0, SDA=bit value; q1,q2 SCL=1; q3 SCL=0. Sample synchronised SDA on last cycle of q2.
- SEND: bits 0-7 = byte; bit 8 SDA released, sample -> m_rsp_data[8].
- RECV: bits 0-7 SDA released, samples shifted into byte; bit 8 SDA = 0 (RECV_ACK) or 1 (RECV_NACK), m_rsp_data[8] = that value.
- Response register loads on BIT completion; holds until m_rsp_ready.
- Arithmetic: quarter counter $clog2(CLKS_PER_QTR) bits, counts down to 0 then reloads; bit index 4 bits, no wrap past 8.

## Timing
- Reset values: o_i2c_scl=1, o_i2c_sda=1, m_rsp_valid=0, m_rsp_data=0, o_busy=0, o_err=0, state IDLE; s_cmd_ready=1 one cycle after reset release.
- Output pad values registered; change exactly at quarter boundaries.
- START/STOP: 4*CLKS_PER_QTR cycles accept->IDLE. Byte: 36*CLKS_PER_QTR cycles accept->m_rsp_valid (plus stretch).
- Rejected command: o_err in cycle after accept; ready again that cycle.
- m_rsp_valid && m_rsp_ready in same cycle as new command: response drains first; ready reasserts next cycle.
- Async reset mid-operation: lines released immediately; o_busy cleared; software recovers with START/STOP.

## Configuration
- I2CM_STRETCH_EN defined: in q1/q2 of any phase with SCL released, quarter counter holds while synchronised SCL reads 0 (slave stretching); the timing figures above then extend by the stretch duration.
- Undefined: counter free-runs; SCL input ignored except for synthesis lint.

## Structure
- Package i2c_pkg: opcode constants, state enum, response bit positions.
- Sub-module i2c_qtr_timer: quarter-tick counter with load, hold (stretch) and tick output; FSM, shifter, synchroniser in top.

## Test plan
- CLKS_PER_QTR=4, START, SEND 0xA0 with bench slave ACK, STOP -> SEND response 0x000; waveform matches per-quarter table; o_busy 1 then 0.
- SEND 0x55 to absent slave (SDA pulled up) -> m_rsp_data=0x100.
- Write 0x00 address then repeated START, SEND 0xA1, RECV_ACK, RECV_NACK against model returning 0x3C,0xC3 -> responses 0x03C, 0x1C3; controller drives SDA low on 9th bit of first RECV only.
- SEND with o_busy=0, opcode 7 -> o_err pulses twice, no SCL/SDA edges, no responses.
- Hold m_rsp_ready=0 after SEND -> s_cmd_ready stays 0 until response accepted.
- I2CM_STRETCH_EN defined, slave holds SCL low 20 cycles in bit 3 -> byte completes 20 cycles later than 36*CLKS_PER_QTR; undefined build -> no delay.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command master: opcodes, FSM states and response layout.
package i2c_pkg;

  localparam logic [2:0] OP_START     = 3'd1;
  localparam logic [2:0] OP_STOP      = 3'd2;
  localparam logic [2:0] OP_SEND      = 3'd3;
  localparam logic [2:0] OP_RECV_ACK  = 3'd4;
  localparam logic [2:0] OP_RECV_NACK = 3'd5;

  localparam int RSP_ACK_BIT = 8;
  localparam int RSP_BYTE_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_STOP,
    ST_BIT
  } state_t;

  function automatic logic is_recv(input logic [2:0] op);
    return (op == OP_RECV_ACK) || (op == OP_RECV_NACK);
  endfunction

  // Only START may be issued while the bus is not owned.
  function automatic logic cmd_legal(input logic [2:0] op, input logic busy);
    case (op)
      OP_START:                                   return 1'b1;
      OP_STOP, OP_SEND, OP_RECV_ACK, OP_RECV_NACK: return busy;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/i2c_qtr_timer.sv
// Quarter-bit tick generator: reloads on load, freezes on hold, ticks on the last cycle of a quarter.
module i2c_qtr_timer #(
  parameter int CLKS_PER_QTR = 250
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic load,
  input  logic hold,
  output logic tick
);
  localparam int CW = (CLKS_PER_QTR > 1) ? $clog2(CLKS_PER_QTR) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_QTR - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == '0) && !hold;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      cnt <= RELOAD;
    else if (load)
      cnt <= RELOAD;
    else if (!hold)
      cnt <= (cnt == '0) ? RELOAD : cnt - CW'(1);
  end

endmodule

// File: rtl/i2c_cmd_master.sv
// Byte-level I2C initiator driven by a START/STOP/SEND/RECV command stream.
// Define I2CM_STRETCH_EN to honour slave clock stretching during the SCL-high quarters.
module i2c_cmd_master
  import i2c_pkg::*;
#(
  parameter int CLKS_PER_QTR = 250
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        s_cmd_valid,
  output logic        s_cmd_ready,
  input  logic [10:0] s_cmd_data,
  output logic        m_rsp_valid,
  input  logic        m_rsp_ready,
  output logic [8:0]  m_rsp_data,
  input  logic        i_i2c_scl,
  input  logic        i_i2c_sda,
  output logic        o_i2c_scl,
  output logic        o_i2c_sda,
  output logic        o_busy,
  output logic        o_err
);
  state_t     state, state_nxt;
  logic [1:0] qtr;
  logic [3:0] bit_idx;
  logic [7:0] shift;
  logic [2:0] op;
  logic [2:0] cmd_op;
  logic [1:0] scl_meta, sda_meta;
  logic       scl_sync, sda_sync;
  logic       sample_bit, tick, hold, accept, cmd_ok, qtr_last;
  logic       scl_drv, sda_drv, rsp_ack;

  assign cmd_op      = s_cmd_data[10:8];
  assign cmd_ok      = cmd_legal(cmd_op, o_busy);
  assign s_cmd_ready = (state == ST_IDLE) && !m_rsp_valid;
  assign accept      = s_cmd_valid && s_cmd_ready;
  assign qtr_last    = tick && (qtr == 2'd3);
  assign scl_sync    = scl_meta[1];
  assign sda_sync    = sda_meta[1];
  assign rsp_ack     = is_recv(op) ? (op == OP_RECV_NACK) : sample_bit;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      scl_meta <= 2'b11;
      sda_meta <= 2'b11;
    end else begin
      scl_meta <= {scl_meta[0], i_i2c_scl};
      sda_meta <= {sda_meta[0], i_i2c_sda};
    end
  end

`ifdef I2CM_STRETCH_EN
  // Only trust a low SCL once our own release has had time to pass the synchroniser.
  logic [1:0] scl_out_d;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) scl_out_d <= 2'b11;
    else            scl_out_d <= {scl_out_d[0], o_i2c_scl};
  end
  assign hold = (state != ST_IDLE) && ((qtr == 2'd1) || (qtr == 2'd2)) &&
                o_i2c_scl && (&scl_out_d) && !scl_sync;
`else
  logic unused_scl;
  assign unused_scl = scl_sync;
  assign hold = 1'b0;
`endif

  i2c_qtr_timer #(.CLKS_PER_QTR(CLKS_PER_QTR)) u_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .load      (accept),
    .hold      (hold),
    .tick      (tick)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (accept && cmd_ok) begin
          case (cmd_op)
            OP_START: state_nxt = ST_START;
            OP_STOP:  state_nxt = ST_STOP;
            default:  state_nxt = ST_BIT;
          endcase
        end
      ST_START, ST_STOP:
        if (qtr_last) state_nxt = ST_IDLE;
      ST_BIT:
        if (qtr_last && (bit_idx == 4'd8)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Desired pad levels for the current quarter; idle keeps whatever the last phase left.
  always_comb begin
    scl_drv = o_i2c_scl;
    sda_drv = o_i2c_sda;
    case (state)
      ST_START:
        case (qtr)
          2'd0:    begin scl_drv = !o_busy; sda_drv = 1'b1; end
          2'd1:    begin scl_drv = 1'b1;    sda_drv = 1'b1; end
          2'd2:    begin scl_drv = 1'b1;    sda_drv = 1'b0; end
          default: begin scl_drv = 1'b0;    sda_drv = 1'b0; end
        endcase
      ST_STOP:
        case (qtr)
          2'd0:    begin scl_drv = 1'b0; sda_drv = 1'b0; end
          2'd1:    begin scl_drv = 1'b1; sda_drv = 1'b0; end
          default: begin scl_drv = 1'b1; sda_drv = 1'b1; end
        endcase
      ST_BIT: begin
        scl_drv = (qtr == 2'd1) || (qtr == 2'd2);
        if (bit_idx == 4'd8) sda_drv = is_recv(op) ? (op == OP_RECV_NACK) : 1'b1;
        else                 sda_drv = is_recv(op) ? 1'b1 : shift[7];
      end
      default: ;
    endcase
  end

  // Datapath: quarter/bit sequencing, shifter, bus ownership and response register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_i2c_scl   <= 1'b1;
      o_i2c_sda   <= 1'b1;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
      m_rsp_valid <= 1'b0;
      m_rsp_data  <= '0;
      qtr         <= 2'd0;
      bit_idx     <= 4'd0;
      shift       <= 8'h00;
      op          <= 3'd0;
      sample_bit  <= 1'b1;
    end else begin
      o_i2c_scl <= scl_drv;
      o_i2c_sda <= sda_drv;
      o_err     <= accept && !cmd_ok;
      if (m_rsp_valid && m_rsp_ready) m_rsp_valid <= 1'b0;
      if (accept && cmd_ok) begin
        qtr     <= 2'd0;
        bit_idx <= 4'd0;
        op      <= cmd_op;
        shift   <= (cmd_op == OP_SEND) ? s_cmd_data[7:0] : 8'h00;
      end else if ((state != ST_IDLE) && tick) begin
        qtr <= qtr + 2'd1;
        if (qtr == 2'd2) sample_bit <= sda_sync;
        if (qtr == 2'd3) begin
          case (state)
            ST_START: o_busy <= 1'b1;
            ST_STOP:  o_busy <= 1'b0;
            ST_BIT:
              if (bit_idx == 4'd8) begin
                m_rsp_valid                   <= 1'b1;
                m_rsp_data[RSP_ACK_BIT]       <= rsp_ack;
                m_rsp_data[RSP_BYTE_W-1:0]    <= is_recv(op) ? shift : 8'h00;
              end else begin
                bit_idx <= bit_idx + 4'd1;
                shift   <= {shift[6:0], sample_bit};
              end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_cmd_master.sv
// Directed bench for i2c_cmd_master: table of commands against a scripted bus slave.
`timescale 1ns/1ps
module tb_i2c_cmd_master;
  import i2c_pkg::*;

  localparam int N = 4;
  localparam int K_CTRL = 0;
  localparam int K_BYTE = 1;
  localparam int K_REJ  = 2;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b1;
  logic        s_cmd_valid = 1'b0;
  logic        s_cmd_ready;
  logic [10:0] s_cmd_data = '0;
  logic        m_rsp_valid;
  logic        m_rsp_ready = 1'b0;
  logic [8:0]  m_rsp_data;
  logic        o_i2c_scl, o_i2c_sda, o_busy, o_err;
  logic        slave_scl = 1'b1;
  logic        slave_sda = 1'b1;
  logic        scl_bus, sda_bus;

  assign scl_bus = o_i2c_scl & slave_scl;
  assign sda_bus = o_i2c_sda & slave_sda;

  i2c_cmd_master #(.CLKS_PER_QTR(N)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .s_cmd_valid (s_cmd_valid),
    .s_cmd_ready (s_cmd_ready),
    .s_cmd_data  (s_cmd_data),
    .m_rsp_valid (m_rsp_valid),
    .m_rsp_ready (m_rsp_ready),
    .m_rsp_data  (m_rsp_data),
    .i_i2c_scl   (scl_bus),
    .i_i2c_sda   (sda_bus),
    .o_i2c_scl   (o_i2c_scl),
    .o_i2c_sda   (o_i2c_sda),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          kind;
    logic [10:0] cmd;
    logic [8:0]  pat;
    logic [8:0]  rsp;
    logic        busy;
  } vec_t;

  vec_t vecs[14];
  int   total = 0;
  int   bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic masterBit(input logic [10:0] cmd, input int k);
    logic [7:0] b;
    b = cmd[7:0];
    if (cmd[10:8] == OP_SEND) return (k < 8) ? b[7-k] : 1'b1;
    return (k < 8) ? 1'b1 : (cmd[10:8] == OP_RECV_NACK);
  endfunction

  task automatic issue(input logic [10:0] cmd);
    s_cmd_data  = cmd;
    s_cmd_valid = 1'b1;
    @(posedge i_clk); #1;
    s_cmd_valid = 1'b0;
  endtask

  task automatic phaseOp(input int idx, input logic [2:0] opc);
    logic [1:0] exp [4];
    int errs, lat;
    if (opc == OP_START) begin
      exp[0] = {!o_busy, 1'b1}; exp[1] = 2'b11; exp[2] = 2'b10; exp[3] = 2'b00;
    end else begin
      exp[0] = 2'b00; exp[1] = 2'b10; exp[2] = 2'b11; exp[3] = 2'b11;
    end
    errs = 0;
    lat  = -1;
    issue({opc, 8'h00});
    for (int c = 1; c <= 4*N + 4; c++) begin
      @(posedge i_clk); #1;
      for (int q = 0; q < 4; q++)
        if (c == q*N + 2 && {o_i2c_scl, o_i2c_sda} !== exp[q]) errs++;
      if (lat < 0 && s_cmd_ready) lat = c;
    end
    checkOutput($sformatf("v%0d.wave", idx), errs, 0);
    checkOutput($sformatf("v%0d.lat", idx), lat, 4*N);
  endtask

  task automatic byteOp(input int idx, input logic [10:0] cmd, input logic [8:0] pat,
                        input logic chk_wave, input int str_start, input int str_len,
                        output int lat, output logic [8:0] got);
    int errs;
    errs = 0;
    lat  = -1;
    issue(cmd);
    for (int c = 1; c <= 36*N + 60; c++) begin
      @(posedge i_clk); #1;
      for (int k = 0; k < 9; k++) begin
        if (c == k*4*N + 2) slave_sda = pat[8-k];
        for (int q = 0; q < 4; q++)
          if (chk_wave && c == k*4*N + q*N + 2) begin
            if (o_i2c_scl !== ((q == 1) || (q == 2)) || o_i2c_sda !== masterBit(cmd, k)) errs++;
          end
      end
      if (c == 35*N + 2) slave_sda = 1'b1;
      if (str_len > 0 && c == str_start) slave_scl = 1'b0;
      if (str_len > 0 && c == str_start + str_len) slave_scl = 1'b1;
      if (m_rsp_valid) begin
        lat = c;
        break;
      end
    end
    slave_sda = 1'b1;
    slave_scl = 1'b1;
    got = m_rsp_data;
    if (chk_wave) checkOutput($sformatf("v%0d.wave", idx), errs, 0);
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk); #1;
      if (s_cmd_ready !== 1'b0 || m_rsp_valid !== 1'b1) errs++;
    end
    checkOutput($sformatf("v%0d.hold", idx), errs, 0);
    m_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    m_rsp_ready = 1'b0;
    checkOutput($sformatf("v%0d.drain", idx), {m_rsp_valid, s_cmd_ready}, 2'b01);
  endtask

  task automatic rejectOp(input int idx, input logic [10:0] cmd);
    logic ps, pd, pb;
    int errs;
    ps = o_i2c_scl; pd = o_i2c_sda; pb = o_busy;
    issue(cmd);
    checkOutput($sformatf("v%0d.err", idx), {o_err, s_cmd_ready}, 2'b11);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clk); #1;
      if (o_err || m_rsp_valid || o_i2c_scl !== ps || o_i2c_sda !== pd || o_busy !== pb) errs++;
    end
    checkOutput($sformatf("v%0d.quiet", idx), errs, 0);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int lat;
    logic [8:0] got;
    case (v.kind)
      K_CTRL: phaseOp(idx, v.cmd[10:8]);
      K_BYTE: begin
        byteOp(idx, v.cmd, v.pat, 1'b1, 0, 0, lat, got);
        checkOutput($sformatf("v%0d.lat", idx), lat, 36*N);
        checkOutput($sformatf("v%0d.rsp", idx), got, v.rsp);
      end
      default: rejectOp(idx, v.cmd);
    endcase
    checkOutput($sformatf("v%0d.busy", idx), o_busy, v.busy);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    logic [8:0] got;

    vecs[0]  = '{K_REJ,  {OP_SEND, 8'h12},      9'h1FF,         9'h000, 1'b0};
    vecs[1]  = '{K_REJ,  {3'd7, 8'h00},         9'h1FF,         9'h000, 1'b0};
    vecs[2]  = '{K_CTRL, {OP_START, 8'h00},     9'h1FF,         9'h000, 1'b1};
    vecs[3]  = '{K_BYTE, {OP_SEND, 8'hA0},      9'h1FE,         9'h000, 1'b1};
    vecs[4]  = '{K_BYTE, {OP_SEND, 8'h00},      9'h1FE,         9'h000, 1'b1};
    vecs[5]  = '{K_CTRL, {OP_START, 8'h00},     9'h1FF,         9'h000, 1'b1};
    vecs[6]  = '{K_BYTE, {OP_SEND, 8'hA1},      9'h1FE,         9'h000, 1'b1};
    vecs[7]  = '{K_BYTE, {OP_RECV_ACK, 8'h00},  {8'h3C, 1'b1},  9'h03C, 1'b1};
    vecs[8]  = '{K_BYTE, {OP_RECV_NACK, 8'h00}, {8'hC3, 1'b1},  9'h1C3, 1'b1};
    vecs[9]  = '{K_CTRL, {OP_STOP, 8'h00},      9'h1FF,         9'h000, 1'b0};
    vecs[10] = '{K_CTRL, {OP_START, 8'h00},     9'h1FF,         9'h000, 1'b1};
    vecs[11] = '{K_BYTE, {OP_SEND, 8'h55},      9'h1FF,         9'h100, 1'b1};
    vecs[12] = '{K_CTRL, {OP_STOP, 8'h00},      9'h1FF,         9'h000, 1'b0};
    vecs[13] = '{K_REJ,  {OP_STOP, 8'h00},      9'h1FF,         9'h000, 1'b0};

    #1 i_reset_n = 1'b0;
    #2;
    checkOutput("reset.pads", {o_i2c_scl, o_i2c_sda}, 2'b11);
    checkOutput("reset.rsp_valid", m_rsp_valid, 1'b0);
    checkOutput("reset.rsp_data", m_rsp_data, 9'h000);
    checkOutput("reset.busy_err", {o_busy, o_err}, 2'b00);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_reset_n = 1'b1;
    @(posedge i_clk); #1;
    checkOutput("reset.ready", s_cmd_ready, 1'b1);

    for (int i = 0; i < 14; i++) applyStimulus(i, vecs[i]);

    // Slave holds SCL low for 20 cycles inside bit 3.
    phaseOp(14, OP_START);
    byteOp(15, {OP_SEND, 8'hA0}, 9'h1FF, 1'b0, 3*4*N + N + 6, 20, lat, got);
`ifdef I2CM_STRETCH_EN
    checkOutput("stretch.lat", (lat >= 36*N + 18) && (lat <= 36*N + 22), 1'b1);
`else
    checkOutput("stretch.lat", lat, 36*N);
`endif

    // Asynchronous reset in the middle of a byte releases the bus at once.
    issue({OP_SEND, 8'h00});
    repeat (40) @(posedge i_clk);
    #1;
    checkOutput("arst.pre", {o_i2c_scl, o_i2c_sda}, 2'b10);
    #2 i_reset_n = 1'b0;
    #1;
    checkOutput("arst.lines", {o_i2c_scl, o_i2c_sda}, 2'b11);
    checkOutput("arst.busy", {o_busy, m_rsp_valid}, 2'b00);
    @(negedge i_clk) i_reset_n = 1'b1;
    @(posedge i_clk); #1;
    checkOutput("arst.ready", s_cmd_ready, 1'b1);
    phaseOp(20, OP_START);
    checkOutput("recover.busy", o_busy, 1'b1);
    phaseOp(21, OP_STOP);
    checkOutput("recover.idle", o_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
